// File: rtl/fastbconv_sched_if.sv
// Control-side bundle between the key-switching requesters, the fastBConv engine strobes and the result consumer.
// master = scheduler, slave = surrounding control logic and engine.
interface fastbconv_sched_if #(
    parameter int NUM_REQ = 2
) ();
    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic               eng_in_valid;
    logic [SEL_W-1:0]   eng_sel;
    logic               eng_out_valid;
    logic               rsp_valid;
    logic [SEL_W-1:0]   rsp_id;
    logic               rsp_ready;
    logic               busy;
    logic               timeout_err;

    modport master (
        input  req_valid, eng_out_valid, rsp_ready,
        output req_ready, eng_in_valid, eng_sel, rsp_valid, rsp_id, busy, timeout_err
    );

    modport slave (
        output req_valid, eng_out_valid, rsp_ready,
        input  req_ready, eng_in_valid, eng_sel, rsp_valid, rsp_id, busy, timeout_err
    );
endinterface

// File: rtl/fastbconv_sched.sv
// Round-robin launcher sharing one fastBConv engine; FBCONV_SCHED_WATCHDOG_EN adds a sticky WAIT timeout.
// Latency: launch is combinational in the grant cycle; rsp_valid rises the cycle after eng_out_valid is seen.
// Backpressure: an unconsumed response blocks all grants; rsp_ready frees it and may launch the next job that cycle.
module fastbconv_sched #(
    parameter int NUM_REQ      = 2,
    parameter int IN_BASIS_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    fastbconv_sched_if.master bus
);
    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int PW    = SEL_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr, cur_id, cur_inc, arb_ptr, grant_idx;
    logic             grant_vld, rsp_done, launch, wd_fire;
    logic [PW-1:0]    scan;

    if (NUM_REQ < 2 || IN_BASIS_LEN < 1) begin : g_param_check
        $error("fastbconv_sched: NUM_REQ must be >= 2 and IN_BASIS_LEN >= 1");
    end

    assign cur_inc  = (cur_id == SEL_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
    assign rsp_done = (state_q == S_RESP) && bus.rsp_ready;
    // A consumed response moves priority past its owner before the same-cycle relaunch is arbitrated
    assign arb_ptr  = rsp_done ? cur_inc : rr_ptr;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, arb_ptr} + PW'(i);
            if (scan >= PW'(NUM_REQ)) scan = scan - PW'(NUM_REQ);
            if (!grant_vld && bus.req_valid[scan[SEL_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[SEL_W-1:0];
            end
        end
    end

    assign launch = reset && grant_vld && ((state_q == S_IDLE) || rsp_done);

`ifdef FBCONV_SCHED_WATCHDOG_EN
    localparam int WD_LIMIT = IN_BASIS_LEN + 4;
    localparam int WD_W     = $clog2(WD_LIMIT);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // wd_cnt is 0 on the first WAIT cycle, so firing at WD_LIMIT-2 shows the flag WD_LIMIT cycles after launch
    assign wd_fire = (state_q == S_WAIT) && !bus.eng_out_valid && (wd_cnt == WD_W'(WD_LIMIT - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= (state_q == S_WAIT) ? wd_cnt + 1'b1 : '0;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign wd_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_ptr  <= '0;
            cur_id  <= '0;
        end else begin
            state_q <= state_d;
            if (rsp_done || wd_fire) rr_ptr <= cur_inc;
            if (launch)              cur_id <= grant_idx;
        end
    end

    // eng_out_valid is only looked at in WAIT; its stale high level in IDLE or the launch cycle is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.eng_out_valid) state_d = S_RESP;
                else if (wd_fire)      state_d = S_IDLE;
            end
            S_RESP:  if (rsp_done) state_d = launch ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.eng_in_valid = launch;
        bus.eng_sel      = launch ? grant_idx : cur_id;
        bus.rsp_valid    = reset && (state_q == S_RESP);
        bus.rsp_id       = cur_id;
        bus.busy         = reset && (state_q != S_IDLE);
        if (launch) bus.req_ready[grant_idx] = 1'b1;
    end
endmodule

// File: tb/tb_fastbconv_sched.sv
// Bench for fastbconv_sched: behavioural engine, round-robin grant model and an expected-response queue.
module tb_fastbconv_sched;
    localparam int NR  = 2;
    localparam int SW  = $clog2(NR);
    localparam int IBL = 4;
    localparam int LAT = IBL + 2;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   m_ptr     = 0;
    int   exp_q[$];
    int   exp_t[$];

    logic eng_ov    = 1'b0;
    int   eng_cnt   = 0;
    logic eng_force = 1'b0;
    logic eng_mute  = 1'b0;

    fastbconv_sched_if #(.NUM_REQ(NR)) bus ();

    fastbconv_sched #(.NUM_REQ(NR), .IN_BASIS_LEN(IBL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine: a launch clears out_valid, which rises IN_BASIS_LEN+1 cycles after launch and then stays high
    always @(posedge clk) begin
        if (bus.eng_in_valid) begin
            eng_ov  <= 1'b0;
            eng_cnt <= IBL;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_ov <= 1'b1;
        end
    end
    assign bus.eng_out_valid = (eng_ov | eng_force) & ~eng_mute;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "bench hung");
    end

    function automatic int arb(input logic [NR-1:0] req, input int ptr);
        for (int i = 0; i < NR; i++)
            if (req[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.req_valid = '1; bus.rsp_ready = 1'b1; eng_force = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== '0 || bus.eng_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: req_ready=%b eng_in_valid=%b, required 00/0", bus.req_ready, bus.eng_in_valid);
        end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.eng_sel !== '0 || bus.rsp_id !== '0 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rsp_valid=%b busy=%b eng_sel=%0d rsp_id=%0d timeout_err=%b, required all 0",
                     bus.rsp_valid, bus.busy, bus.eng_sel, bus.rsp_id, bus.timeout_err);
        end
        bus.req_valid = '0; eng_force = 1'b0;
        next_cycle(); reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.eng_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rsp_valid=%b eng_in_valid=%b, required 0/0/0", bus.busy, bus.rsp_valid, bus.eng_in_valid);
        end
        m_ptr = 0;
    endtask

    task automatic test_single();
        int g; bit got;
        bus.rsp_ready = 1'b1;
        repeat (2) next_cycle();
        bus.req_valid = 2'b01; g = arb(2'b01, m_ptr);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== NR'(1 << g) || bus.eng_in_valid !== 1'b1 || bus.eng_sel !== SW'(g)) begin
            n_fail++;
            $display("FAIL single_launch: req_ready=%b eng_in_valid=%b eng_sel=%0d, required %b/1/%0d", bus.req_ready, bus.eng_in_valid, bus.eng_sel, NR'(1 << g), g);
        end
        exp_q.push_back(g); exp_t.push_back(cyc + LAT);
        next_cycle(); bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.eng_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait: busy=%b rsp_valid=%b eng_in_valid=%b, required 1/0/0", bus.busy, bus.rsp_valid, bus.eng_in_valid);
        end
        got = 0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            next_cycle(); @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1; n_tests++;
                if (cyc != exp_t[0] || bus.rsp_id !== SW'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL single_rsp: cycle=%0d id=%0d, required cycle=%0d id=%0d", cyc, bus.rsp_id, exp_t[0], exp_q[0]);
                end
                m_ptr = (exp_q[0] + 1) % NR;
                void'(exp_q.pop_front()); void'(exp_t.pop_front());
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL single_rsp_timeout: rsp_valid=0 after %0d cycles, required 1", 3 * LAT);
        end
        next_cycle(); @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b rsp_valid=%b, required 0/0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int launches, last_t, g; logic [NR-1:0] req;
        launches = 0; last_t = -1;
        bus.rsp_ready = 1'b1;
        next_cycle(); req = 2'b11; bus.req_valid = req;
        for (int k = 0; k < 8 * LAT && (launches < 4 || exp_q.size() > 0); k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0 || cyc != exp_t[0] || bus.rsp_id !== SW'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL rr_rsp: cycle=%0d id=%0d, required queued response (pending=%0d)", cyc, bus.rsp_id, exp_q.size());
                end
                if (exp_q.size() > 0) begin
                    m_ptr = (exp_q[0] + 1) % NR;
                    void'(exp_q.pop_front()); void'(exp_t.pop_front());
                end
            end
            if (bus.eng_in_valid === 1'b1) begin
                g = arb(req, m_ptr);
                n_tests++;
                if (g < 0 || bus.req_ready !== NR'(1 << g) || bus.eng_sel !== SW'(g) ||
                    (last_t >= 0 && (cyc != last_t + LAT || bus.rsp_valid !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL rr_launch: cycle=%0d req_ready=%b eng_sel=%0d, required grant %0d at cycle %0d",
                             cyc, bus.req_ready, bus.eng_sel, g, (last_t >= 0) ? last_t + LAT : cyc);
                end
                exp_q.push_back(g); exp_t.push_back(cyc + LAT);
                last_t = cyc; launches++;
            end
            next_cycle();
            if (launches >= 4) begin req = '0; bus.req_valid = req; end
        end
        if (launches < 4 || exp_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL rr_timeout: launches=%0d pending=%0d, required 4/0", launches, exp_q.size());
            exp_q.delete(); exp_t.delete();
        end
    endtask

    task automatic test_backpressure();
        int g0, g1, t1; bit got;
        bus.rsp_ready = 1'b0;
        next_cycle(); bus.req_valid = 2'b01; g0 = arb(2'b01, m_ptr);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== NR'(1 << g0) || bus.eng_in_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_launch: req_ready=%b eng_in_valid=%b, required %b/1", bus.req_ready, bus.eng_in_valid, NR'(1 << g0));
        end
        next_cycle(); bus.req_valid = 2'b10;
        got = 0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) got = 1;
            else begin
                n_tests++;
                if (bus.req_ready !== '0 || bus.eng_in_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_wait_grant: req_ready=%b eng_in_valid=%b, required 00/0", bus.req_ready, bus.eng_in_valid);
                end
                next_cycle();
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL bp_rsp_timeout: rsp_valid=0, required 1");
        end
        for (int k = 0; k < 20; k++) begin
            next_cycle(); @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== SW'(g0) || bus.req_ready !== '0 || bus.eng_in_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: rsp_valid=%b rsp_id=%0d req_ready=%b eng_in_valid=%b, required 1/%0d/00/0",
                         bus.rsp_valid, bus.rsp_id, bus.req_ready, bus.eng_in_valid, g0);
            end
        end
        next_cycle(); bus.rsp_ready = 1'b1;
        m_ptr = (g0 + 1) % NR; g1 = arb(2'b10, m_ptr);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== NR'(1 << g1) || bus.eng_in_valid !== 1'b1 || bus.eng_sel !== SW'(g1) || bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: req_ready=%b eng_in_valid=%b eng_sel=%0d rsp_valid=%b, required %b/1/%0d/1",
                     bus.req_ready, bus.eng_in_valid, bus.eng_sel, bus.rsp_valid, NR'(1 << g1), g1);
        end
        exp_q.push_back(g1); exp_t.push_back(cyc + LAT);
        next_cycle(); bus.req_valid = '0;
        got = 0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1; n_tests++;
                t1 = exp_t.pop_front();
                if (cyc != t1 || bus.rsp_id !== SW'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL bp_second_rsp: cycle=%0d id=%0d, required cycle=%0d id=%0d", cyc, bus.rsp_id, t1, exp_q[0]);
                end
                m_ptr = (exp_q.pop_front() + 1) % NR;
            end
            next_cycle();
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL bp_second_timeout: rsp_valid=0, required 1");
            exp_q.delete(); exp_t.delete();
        end
    endtask

    task automatic test_stale_out_valid();
        int g, t0; bit got;
        bus.rsp_ready = 1'b1;
        next_cycle(); eng_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_idle: rsp_valid=%b busy=%b, required 0/0", bus.rsp_valid, bus.busy);
            end
            next_cycle();
        end
        bus.req_valid = 2'b01; g = arb(2'b01, m_ptr);
        @(negedge clk); t0 = cyc;
        next_cycle(); eng_force = 1'b0; bus.req_valid = '0;
        got = 0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1; n_tests++;
                if (cyc != t0 + LAT || bus.rsp_id !== SW'(g)) begin
                    n_fail++;
                    $display("FAIL stale_rsp: cycle=%0d id=%0d, required cycle=%0d id=%0d", cyc, bus.rsp_id, t0 + LAT, g);
                end
                m_ptr = (g + 1) % NR;
            end
            next_cycle();
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL stale_timeout: rsp_valid=0, required 1");
        end
    endtask

    task automatic test_reset_mid_wait();
        int g, t0; bit got;
        bus.rsp_ready = 1'b1;
        next_cycle(); bus.req_valid = 2'b01;
        next_cycle(); bus.req_valid = '0;
        next_cycle(); bus.req_valid = 2'b11; reset = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== '0 || bus.eng_in_valid !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_reset: busy=%b req_ready=%b eng_in_valid=%b rsp_valid=%b, required all 0",
                     bus.busy, bus.req_ready, bus.eng_in_valid, bus.rsp_valid);
        end
        eng_force = 1'b1;
        next_cycle(); bus.req_valid = '0;
        next_cycle(); reset = 1'b1; m_ptr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midwait_after: rsp_valid=%b busy=%b, required 0/0", bus.rsp_valid, bus.busy);
            end
            next_cycle();
        end
        bus.req_valid = 2'b11; g = arb(2'b11, m_ptr);
        @(negedge clk); t0 = cyc;
        n_tests++;
        if (bus.req_ready !== NR'(1 << g) || bus.eng_in_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_ptr: req_ready=%b eng_in_valid=%b, required %b/1", bus.req_ready, bus.eng_in_valid, NR'(1 << g));
        end
        next_cycle(); eng_force = 1'b0; bus.req_valid = '0;
        got = 0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1; n_tests++;
                if (cyc != t0 + LAT || bus.rsp_id !== SW'(g)) begin
                    n_fail++;
                    $display("FAIL midwait_rsp: cycle=%0d id=%0d, required cycle=%0d id=%0d", cyc, bus.rsp_id, t0 + LAT, g);
                end
                m_ptr = (g + 1) % NR;
            end
            next_cycle();
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL midwait_timeout: rsp_valid=0, required 1");
        end
    endtask

`ifdef FBCONV_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int g;
        bus.rsp_ready = 1'b1;
        next_cycle(); eng_mute = 1'b1; bus.req_valid = 2'b01; g = arb(2'b01, m_ptr);
        @(negedge clk);
        n_tests++;
        if (bus.eng_in_valid !== 1'b1 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_launch: eng_in_valid=%b timeout_err=%b, required 1/0", bus.eng_in_valid, bus.timeout_err);
        end
        next_cycle(); bus.req_valid = '0;
        for (int k = 1; k <= IBL + 4; k++) begin
            @(negedge clk);
            n_tests++;
            if ((k < IBL + 4 && (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0)) ||
                (k == IBL + 4 && (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0))) begin
                n_fail++;
                $display("FAIL wd_count: launch+%0d timeout_err=%b busy=%b rsp_valid=%b, required %b/%b/0",
                         k, bus.timeout_err, bus.busy, bus.rsp_valid, k == IBL + 4, k < IBL + 4);
            end
            next_cycle();
        end
        m_ptr = (g + 1) % NR; eng_mute = 1'b0;
        bus.req_valid = 2'b11; g = arb(2'b11, m_ptr);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== NR'(1 << g) || bus.eng_in_valid !== 1'b1 || bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_next: req_ready=%b eng_in_valid=%b timeout_err=%b, required %b/1/1",
                     bus.req_ready, bus.eng_in_valid, bus.timeout_err, NR'(1 << g));
        end
        next_cycle(); bus.req_valid = '0;
        repeat (LAT) next_cycle();
        @(negedge clk);
        n_tests++;
        if (bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: timeout_err=%b, required 1", bus.timeout_err);
        end
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stale_out_valid();
        test_reset_mid_wait();
`ifdef FBCONV_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fastbconv_sched.md
# fastbconv_sched

Round-robin scheduler that shares one `fastBConv` engine among `NUM_REQ` requesters (e.g. ModUp and ModDown paths). It accepts one conversion request at a time and drives the engine's `in_valid` pulse and input-mux select. It waits for the engine's `out_valid`, then holds a response until the consumer acknowledges it, so the engine's output register is never cleared by a new launch before it is read. It sits between the key-switching control path and the `fastBConv` instance; data buses do not pass through it.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥2.
- `IN_BASIS_LEN`, 4: input basis length of the controlled engine. Used only for the watchdog limit.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `reset` in 1: reset is asynchronous and active-low. Asserted at 0.
- `req_valid` in `NUM_REQ`: per-requester request; held until accepted.
- `req_ready` out `NUM_REQ`: one-hot accept strobe; combinational.
- `eng_in_valid` out 1: start pulse to the engine `in_valid`; combinational.
- `eng_sel` out `$clog2(NUM_REQ)`: engine input-mux select. Valid whenever `eng_in_valid`=1, registered otherwise.
- `eng_out_valid` in 1: engine `out_valid` (level, stays high after completion).
- `rsp_valid` out 1: engine result ready for consumer.
- `rsp_id` out `$clog2(NUM_REQ)`: requester that owns the current job.
- `rsp_ready` in 1: consumer has taken the engine output this cycle.
- `busy` out 1: high in WAIT or RESP.
- `timeout_err` out 1: sticky watchdog error. Constant 0 unless the watchdog macro is defined.

## Operation
FSM states:
- IDLE
  - If any `req_valid`, the round-robin winner g is chosen. The search starts at `rr_ptr`, wrapping NUM_REQ-1→0.
  - The same cycle: `req_ready[g]`=1, `eng_in_valid`=1, `eng_sel`=g. Next state is WAIT, with `cur_id` latched to g.
  - Otherwise stay in IDLE with all strobes 0.
- WAIT
  - `eng_out_valid` is sampled only in this state. The launch-cycle (stale high) value is never observed, because the engine clears it at the launch edge.
  - On `eng_out_valid`=1, next state is RESP.
- RESP
  - `rsp_valid`=1, `rsp_id`=`cur_id`.
  - On `rsp_ready`=1, `rr_ptr`←`cur_id`+1 (mod `NUM_REQ`).
  - Same cycle: if any `req_valid`, a new winner is granted and launched directly (RESP→WAIT), arbitrated from the updated pointer computed combinationally. Otherwise next state is IDLE.
  - Without `rsp_ready`, hold indefinitely. No launch is issued while a response is unconsumed.

Arbitration rules:
- At most one `req_ready` bit is set per cycle. `req_ready` is never set in WAIT, or in RESP without `rsp_ready`.
- `req_valid` dropped before acceptance is legal; it simply loses arbitration.

## Timing
- Launch at cycle t (`eng_in_valid`=1). The engine asserts `eng_out_valid` at t+`IN_BASIS_LEN`+1. `rsp_valid` rises at t+`IN_BASIS_LEN`+2.
- Back-to-back throughput: one job per `IN_BASIS_LEN`+2 cycles when `rsp_ready` is tied high.
- Reset (`reset`=0, asynchronous):
  - FSM→IDLE, `rr_ptr`=0, `cur_id`=0, `timeout_err`=0.
  - All outputs 0, including the combinational strobes, which are gated by reset.
  - Release is synchronous to `clk`.
- Reset mid-WAIT or mid-RESP: the job is dropped and no response is issued. A stale engine `out_valid` is ignored until the next launch.
- Simultaneous `rsp_ready` and new requests in RESP: the response completes and the new launch occurs in the same cycle. Priority follows the post-update pointer.

## Configuration
- `FBCONV_SCHED_WATCHDOG_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches `IN_BASIS_LEN`+4 without `eng_out_valid`:
    - `timeout_err` is set sticky until reset.
    - The job is dropped with no `rsp_valid`, FSM→IDLE, and `rr_ptr`←`cur_id`+1.
- Not defined:
  - No counter; WAIT persists until `eng_out_valid`.
  - `timeout_err` is constant 0.

## Test plan
- Single request: `NUM_REQ`=2, `IN_BASIS_LEN`=4, `req_valid`=01 at cycle 5 → `req_ready`=01 and `eng_in_valid`=1 at cycle 5, `eng_sel`=0; `rsp_valid`=1 with `rsp_id`=0 at cycle 11.
- Round robin: `req_valid`=11 held, `rsp_ready`=1 → grants alternate 0,1,0,1 every 6 cycles. A back-to-back launch occurs in each RESP cycle.
- Backpressure: `rsp_ready`=0 for 20 cycles with `req_valid`=10 pending → no `req_ready`, no `eng_in_valid`, `rsp_valid` held. First `rsp_ready`=1 → `req_ready`=10 in the same cycle.
- Stale `out_valid`: `eng_out_valid` forced 1 during IDLE and on the launch cycle → no `rsp_valid` until the model re-raises it at t+5.
- Reset mid-WAIT: `reset`=0 two cycles after launch → all outputs 0 immediately. After release, no `rsp_valid` despite `eng_out_valid`=1 at idle.
- Watchdog (macro on): `eng_out_valid` held 0 after launch → `timeout_err`=1 at launch+8 cycles, FSM IDLE. The next request is accepted and `timeout_err` stays 1.
